rr_trace_buf_ctrl: RTL and testbench
====================================

Name: rr_trace_buf_ctrl

Overview:
Descriptor scheduler that sequences the record/replay trace engine (rr_trace_rw).
- Host software posts trace buffer descriptors (64-bit addr, 64-bit size) for the write side (record) and the read side (replay).
- The block queues the descriptors and hands each one to the engine with a single-cycle write_buf_update / read_buf_update pulse.
- It advances to the next descriptor on each buffer-exhausted interrupt, and gates the record-finish request so it only reaches the engine while a write buffer is loaded.

Parameters:
DESC_DEPTH, 4, descriptor FIFO depth per side (power of 2, ≥2)
AXI_ADDR_WIDTH, 64, address/size width
ALIGN_BYTES, 64, required alignment of addr and size (one 512-bit AXI beat)
CNT_WIDTH, 16, width of completed-buffer counters

Ports:
clk  in  1  clock
sync_rst_n  in  1  reset, asynchronous assert, active-low
desc_valid  in  1  host descriptor valid
desc_ready  out  1  descriptor accepted this cycle when valid&ready
desc_is_read  in  1  0=write(record) queue, 1=read(replay) queue
desc_addr  in  AXI_ADDR_WIDTH  buffer base address
desc_size  in  AXI_ADDR_WIDTH  buffer size in bytes
host_finish  in  1  one-cycle record-finish request
write_buf_addr  out  AXI_ADDR_WIDTH  to engine
write_buf_size  out  AXI_ADDR_WIDTH  to engine
write_buf_update  out  1  one-cycle load pulse
write_interrupt  in  1  engine: write buffer exhausted
read_buf_addr  out  AXI_ADDR_WIDTH  to engine
read_buf_size  out  AXI_ADDR_WIDTH  to engine
read_buf_update  out  1  one-cycle load pulse
read_interrupt  in  1  engine: read buffer exhausted
record_finish  out  1  one-cycle finish pulse to engine
wr_starved  out  1  write side exhausted, queue empty
rd_starved  out  1  read side exhausted, queue empty
wr_done_cnt  out  CNT_WIDTH  completed write buffers
rd_done_cnt  out  CNT_WIDTH  completed read buffers
err_sticky  out  3  [0] bad descriptor, [1] spurious wr interrupt, [2] spurious rd interrupt

Behaviour:
Reset values
- All outputs 0, except desc_ready, which resets to 1.
- FIFOs empty, both side FSMs in IDLE, finish_pend=0.

Descriptor intake
- desc_ready is 1 when the targeted FIFO (selected by desc_is_read) is not full.
- Bad descriptor: size==0, or addr or size not a multiple of ALIGN_BYTES.
  - It is consumed (ready=1), dropped, and sets err_sticky[0].
  - It is never pushed.
- Push and pop of the same FIFO in one cycle are both honoured; occupancy is unchanged.

Per-side FSM (write and read identical and independent): IDLE, LOAD, ACTIVE, STARVED
- IDLE: FIFO non-empty -> LOAD.
- LOAD (exactly 1 cycle):
  - pop FIFO head;
  - drive *_buf_addr/_size from the head (registered, held until the next LOAD);
  - *_buf_update=1;
  - next state ACTIVE.
- ACTIVE:
  - *_interrupt=1 increments *_done_cnt (wraps at 2^CNT_WIDTH).
  - On that interrupt: FIFO non-empty -> LOAD; empty -> STARVED.
- STARVED:
  - *_starved=1;
  - FIFO non-empty -> LOAD.
- *_interrupt in IDLE/LOAD/STARVED: ignored, and sets err_sticky[1]/[2].

Latency
- A descriptor accepted at edge k into an empty FIFO with the side in IDLE/STARVED gives *_buf_update high in the cycle after edge k+2.
- With a queued descriptor, an interrupt at edge k gives update in the cycle after edge k+1.

Finish
- host_finish sets finish_pend.
- record_finish pulses for 1 cycle when finish_pend=1 and the write FSM is ACTIVE; finish_pend clears in the same cycle.
- host_finish while finish_pend=1: no additional effect.

Reset mid-operation
- Asynchronous: everything returns to reset values immediately.
- Queued descriptors are discarded; any in-flight update pulse is truncated.

Decomposition:
Package rr_trace_buf_pkg holds:
- typedef rr_buf_desc_t {addr, size};
- enum rr_buf_state_e {IDLE, LOAD, ACTIVE, STARVED};
- constant ALIGN_MASK.

Sub-module rr_buf_desc_fifo (synchronous FIFO of rr_buf_desc_t, full/empty, DESC_DEPTH) is instantiated twice. The per-side FSM is a generate loop or a repeated always block in the top.

Test Plan:
- Write descriptor {0x10000000, 1024} after reset -> write_buf_update pulse 2 cycles later, addr=0x10000000, size=1024; write FSM ACTIVE.
- Push 2 write descriptors, then pulse write_interrupt twice -> second update 1 cycle after first interrupt; after the second interrupt wr_starved=1, wr_done_cnt=2.
- Push 5 write descriptors back-to-back with DESC_DEPTH=4 and the FSM holding the first in LOAD/ACTIVE -> desc_ready drops only when the FIFO holds 4; none lost; no update without interrupts.
- Descriptors with size=0, and with addr=0x10000020 -> dropped, err_sticky[0]=1, no update pulse; read_interrupt while read side IDLE -> err_sticky[2]=1.
- host_finish with no write buffer -> no record_finish; then load a descriptor -> record_finish pulses exactly once, in the first ACTIVE cycle.
- Deassert sync_rst_n while ACTIVE with 2 queued descriptors -> outputs immediately 0; after release no update until a new descriptor is posted.

Source files
------------

// File: rtl/rr_trace_buf_ctrl_pkg.sv
// Shared types and constants for the record/replay trace descriptor scheduler.
package rr_trace_buf_pkg;

  localparam int RR_ADDR_W      = 64;
  localparam int RR_ALIGN_BYTES = 64;
  localparam logic [RR_ADDR_W-1:0] ALIGN_MASK = RR_ADDR_W'(RR_ALIGN_BYTES - 1);

  typedef struct packed {
    logic [RR_ADDR_W-1:0] addr;
    logic [RR_ADDR_W-1:0] size;
  } rr_buf_desc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ACTIVE  = 2'd2,
    STARVED = 2'd3
  } rr_buf_state_e;

  // A descriptor is unusable if it is empty or not beat-aligned in base or length.
  function automatic logic desc_bad(input rr_buf_desc_t d, input logic [RR_ADDR_W-1:0] mask);
    return (d.size == '0) || ((d.addr & mask) != '0) || ((d.size & mask) != '0);
  endfunction

endpackage

// File: rtl/rr_trace_buf_ctrl_if.sv
// Host-side descriptor posting bus: valid/ready handshake plus descriptor payload.
interface rr_trace_buf_ctrl_if;
  import rr_trace_buf_pkg::*;

  logic                 desc_valid;
  logic                 desc_ready;
  logic                 desc_is_read;
  logic [RR_ADDR_W-1:0] desc_addr;
  logic [RR_ADDR_W-1:0] desc_size;

  modport master (
    output desc_valid, desc_is_read, desc_addr, desc_size,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, desc_is_read, desc_addr, desc_size,
    output desc_ready
  );
endinterface

// File: rtl/rr_trace_buf_ctrl_fifo.sv
// Small synchronous descriptor FIFO; head is visible combinationally for the loader.
module rr_buf_desc_fifo
  import rr_trace_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sync_rst_n,
  input  logic         push,
  input  rr_buf_desc_t push_data,
  input  logic         pop,
  output rr_buf_desc_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  rr_buf_desc_t mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer advance; simultaneous push and pop both take effect.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the queue and discards its contents.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rr_trace_buf_ctrl.sv
// Descriptor scheduler for the record/replay trace engine: queues host buffer
// descriptors per side and hands them to the engine one at a time.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no buffer ever loaded since reset, waiting for a descriptor
//   LOAD    | popping the queue head, load pulse issued on exit
//   ACTIVE  | engine owns a buffer, waiting for its exhausted interrupt
//   STARVED | engine exhausted its buffer and the queue is empty
module rr_trace_buf_ctrl
  import rr_trace_buf_pkg::*;
#(
  parameter int DESC_DEPTH     = 4,
  parameter int AXI_ADDR_WIDTH = RR_ADDR_W,
  parameter int ALIGN_BYTES    = RR_ALIGN_BYTES,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      sync_rst_n,
  rr_trace_buf_ctrl_if.slave        desc_if,
  input  logic                      host_finish,
  output logic [AXI_ADDR_WIDTH-1:0] write_buf_addr,
  output logic [AXI_ADDR_WIDTH-1:0] write_buf_size,
  output logic                      write_buf_update,
  input  logic                      write_interrupt,
  output logic [AXI_ADDR_WIDTH-1:0] read_buf_addr,
  output logic [AXI_ADDR_WIDTH-1:0] read_buf_size,
  output logic                      read_buf_update,
  input  logic                      read_interrupt,
  output logic                      record_finish,
  output logic                      wr_starved,
  output logic                      rd_starved,
  output logic [CNT_WIDTH-1:0]      wr_done_cnt,
  output logic [CNT_WIDTH-1:0]      rd_done_cnt,
  output logic [2:0]                err_sticky
);

  localparam logic [RR_ADDR_W-1:0] ALIGN_M = RR_ADDR_W'(ALIGN_BYTES - 1);

  rr_buf_desc_t                    in_desc;
  logic                            in_bad, in_fire;
  logic [1:0]                      fifo_full, fifo_empty, side_push;
  logic [1:0]                      side_upd, side_starved, side_spur;
  rr_buf_desc_t [1:0]              side_buf;
  logic [1:0][CNT_WIDTH-1:0]       side_cnt;
  logic                            wr_active_nxt;
  logic                            bad_q, bad_d;
  logic                            fin_pend_q, fin_pend_d;
  logic                            rec_fin_q, rec_fin_d;

  // Bad descriptors are always accepted so the host never stalls on them.
  assign in_desc            = {desc_if.desc_addr, desc_if.desc_size};
  assign in_bad             = desc_bad(in_desc, ALIGN_M);
  assign desc_if.desc_ready = in_bad || !fifo_full[desc_if.desc_is_read];
  assign in_fire            = desc_if.desc_valid && desc_if.desc_ready;
  assign side_push[0]       = in_fire && !in_bad && !desc_if.desc_is_read;
  assign side_push[1]       = in_fire && !in_bad &&  desc_if.desc_is_read;

  for (genvar s = 0; s < 2; s++) begin : g_side
    rr_buf_state_e        state_q, state_d;
    rr_buf_desc_t         head, buf_q, buf_d;
    logic                 irq, upd_q, upd_d, starved_q, starved_d, spur_q, spur_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign irq = (s == 0) ? write_interrupt : read_interrupt;

    rr_buf_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
      .clk       (clk),
      .sync_rst_n(sync_rst_n),
      .push      (side_push[s]),
      .push_data (in_desc),
      .pop       (state_q == LOAD),
      .head      (head),
      .full      (fifo_full[s]),
      .empty     (fifo_empty[s])
    );

    // Next state and next registered outputs for this side.
    always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      upd_d   = 1'b0;
      cnt_d   = cnt_q;
      spur_d  = spur_q;
      unique case (state_q)
        IDLE, STARVED: if (!fifo_empty[s]) state_d = LOAD;
        LOAD: begin
          state_d = ACTIVE;
          buf_d   = head;
          upd_d   = 1'b1;
        end
        ACTIVE: if (irq) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = fifo_empty[s] ? STARVED : LOAD;
        end
        default: state_d = IDLE;
      endcase
      if (irq && state_q != ACTIVE) spur_d = 1'b1;
      starved_d = (state_d == STARVED);
    end

    // Side FSM state and its registered outputs.
    always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
        state_q   <= IDLE;
        buf_q     <= '0;
        upd_q     <= 1'b0;
        cnt_q     <= '0;
        starved_q <= 1'b0;
        spur_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        buf_q     <= buf_d;
        upd_q     <= upd_d;
        cnt_q     <= cnt_d;
        starved_q <= starved_d;
        spur_q    <= spur_d;
      end
    end

    assign side_upd[s]     = upd_q;
    assign side_starved[s] = starved_q;
    assign side_spur[s]    = spur_q;
    assign side_buf[s]     = buf_q;
    assign side_cnt[s]     = cnt_q;

    if (s == 0) begin : g_wr
      assign wr_active_nxt = (state_d == ACTIVE);
    end
  end

  // Finish request is held until a write buffer is live, then forwarded once.
  always_comb begin
    bad_d      = bad_q || (in_fire && in_bad);
    rec_fin_d  = fin_pend_q && wr_active_nxt;
    fin_pend_d = rec_fin_d ? 1'b0 : (fin_pend_q || host_finish);
  end

  // Finish and bad-descriptor registers.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      bad_q      <= 1'b0;
      fin_pend_q <= 1'b0;
      rec_fin_q  <= 1'b0;
    end else begin
      bad_q      <= bad_d;
      fin_pend_q <= fin_pend_d;
      rec_fin_q  <= rec_fin_d;
    end
  end

  assign write_buf_addr   = AXI_ADDR_WIDTH'(side_buf[0].addr);
  assign write_buf_size   = AXI_ADDR_WIDTH'(side_buf[0].size);
  assign write_buf_update = side_upd[0];
  assign read_buf_addr    = AXI_ADDR_WIDTH'(side_buf[1].addr);
  assign read_buf_size    = AXI_ADDR_WIDTH'(side_buf[1].size);
  assign read_buf_update  = side_upd[1];
  assign record_finish    = rec_fin_q;
  assign wr_starved       = side_starved[0];
  assign rd_starved       = side_starved[1];
  assign wr_done_cnt      = side_cnt[0];
  assign rd_done_cnt      = side_cnt[1];
  assign err_sticky       = {side_spur[1], side_spur[0], bad_q};

endmodule

// File: tb/tb_rr_trace_buf_ctrl.sv
// Scoreboard bench for rr_trace_buf_ctrl: every accepted good descriptor is
// queued as an expected load and compared when the matching update pulse appears.
module tb_rr_trace_buf_ctrl;
  import rr_trace_buf_pkg::*;

  logic        clk = 1'b0;
  logic        sync_rst_n = 1'b0;
  logic        host_finish = 1'b0;
  logic        write_interrupt = 1'b0;
  logic        read_interrupt = 1'b0;
  logic [63:0] write_buf_addr, write_buf_size, read_buf_addr, read_buf_size;
  logic        write_buf_update, read_buf_update, record_finish;
  logic        wr_starved, rd_starved;
  logic [15:0] wr_done_cnt, rd_done_cnt;
  logic [2:0]  err_sticky;

  rr_trace_buf_ctrl_if dif();

  rr_trace_buf_ctrl u_dut (
    .clk             (clk),
    .sync_rst_n      (sync_rst_n),
    .desc_if         (dif),
    .host_finish     (host_finish),
    .write_buf_addr  (write_buf_addr),
    .write_buf_size  (write_buf_size),
    .write_buf_update(write_buf_update),
    .write_interrupt (write_interrupt),
    .read_buf_addr   (read_buf_addr),
    .read_buf_size   (read_buf_size),
    .read_buf_update (read_buf_update),
    .read_interrupt  (read_interrupt),
    .record_finish   (record_finish),
    .wr_starved      (wr_starved),
    .rd_starved      (rd_starved),
    .wr_done_cnt     (wr_done_cnt),
    .rd_done_cnt     (rd_done_cnt),
    .err_sticky      (err_sticky)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] wr_q[$];
  logic [127:0] rd_q[$];
  int           wr_upd_n = 0;
  int           rd_upd_n = 0;
  int           rec_fin_n = 0;
  logic         rec_fin_upd = 1'b0;
  int           wait_sum = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare each load pulse against the oldest expected descriptor.
  always @(negedge clk) begin
    if (sync_rst_n) begin
      if (write_buf_update) begin
        wr_upd_n++;
        if (wr_q.size() == 0) chk("wr_upd_unexpected", 128'(write_buf_update), 128'(0));
        else chk("wr_upd_desc", {write_buf_addr, write_buf_size}, wr_q.pop_front());
      end
      if (read_buf_update) begin
        rd_upd_n++;
        if (rd_q.size() == 0) chk("rd_upd_unexpected", 128'(read_buf_update), 128'(0));
        else chk("rd_upd_desc", {read_buf_addr, read_buf_size}, rd_q.pop_front());
      end
      if (record_finish) begin
        rec_fin_n++;
        rec_fin_upd = write_buf_update;
      end
    end
  end

  task automatic post(input logic rd, input logic [63:0] a, input logic [63:0] s, input bit good);
    int n;
    dif.desc_valid   = 1'b1;
    dif.desc_is_read = rd;
    dif.desc_addr    = a;
    dif.desc_size    = s;
    #1;
    n = 0;
    while (!dif.desc_ready && n < 40) begin
      tick();
      n++;
    end
    wait_sum += n;
    if (n == 40) chk("desc_ready_timeout", 128'(dif.desc_ready), 128'(1));
    else if (good) begin
      if (rd) rd_q.push_back({a, s});
      else    wr_q.push_back({a, s});
    end
    tick();
    dif.desc_valid = 1'b0;
  endtask

  task automatic wait_wr_upd(input int target);
    int n = 0;
    while (wr_upd_n < target && n < 30) begin tick(); n++; end
    if (wr_upd_n < target) chk("wr_upd_timeout", 128'(wr_upd_n), 128'(target));
  endtask

  task automatic wait_rd_upd(input int target);
    int n = 0;
    while (rd_upd_n < target && n < 30) begin tick(); n++; end
    if (rd_upd_n < target) chk("rd_upd_timeout", 128'(rd_upd_n), 128'(target));
  endtask

  task automatic pulse_wr_irq();
    write_interrupt = 1'b1;
    tick();
    write_interrupt = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    sync_rst_n = 1'b0;
    wr_q.delete();
    rd_q.delete();
    wr_upd_n = 0;
    rd_upd_n = 0;
    rec_fin_n = 0;
    rec_fin_upd = 1'b0;
    wait_sum = 0;
    repeat (2) @(posedge clk);
    #3;
    sync_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    dif.desc_valid   = 1'b0;
    dif.desc_is_read = 1'b0;
    dif.desc_addr    = '0;
    dif.desc_size    = '0;
    do_reset();

    // Reset values
    chk("rst_desc_ready", 128'(dif.desc_ready), 128'(1));
    chk("rst_wr_update",  128'(write_buf_update), 128'(0));
    chk("rst_wr_addr",    128'(write_buf_addr), 128'(0));
    chk("rst_err",        128'(err_sticky), 128'(0));
    chk("rst_starved",    128'({wr_starved, rd_starved, record_finish}), 128'(0));
    chk("rst_cnts",       128'({wr_done_cnt, rd_done_cnt}), 128'(0));

    // Single write descriptor: update in the cycle after edge k+2
    post(1'b0, 64'h1000_0000, 64'd1024, 1'b1);
    chk("t1_upd_k",  128'(write_buf_update), 128'(0));
    tick();
    chk("t1_upd_k1", 128'(write_buf_update), 128'(0));
    tick();
    chk("t1_upd_k2", 128'(write_buf_update), 128'(1));
    chk("t1_addr",   128'(write_buf_addr), 128'(64'h1000_0000));
    chk("t1_size",   128'(write_buf_size), 128'(1024));
    tick();
    chk("t1_upd_once", 128'(write_buf_update), 128'(0));
    chk("t1_active_not_starved", 128'(wr_starved), 128'(0));

    // Two queued descriptors, two interrupts
    do_reset();
    post(1'b0, 64'h2000_0000, 64'h400, 1'b1);
    post(1'b0, 64'h2000_1000, 64'h800, 1'b1);
    wait_wr_upd(1);
    write_interrupt = 1'b1;
    tick();
    write_interrupt = 1'b0;
    chk("t2_upd_k",   128'(write_buf_update), 128'(0));
    tick();
    chk("t2_upd_k1",  128'(write_buf_update), 128'(1));
    chk("t2_addr2",   128'(write_buf_addr), 128'(64'h2000_1000));
    tick();
    chk("t2_not_starved", 128'(wr_starved), 128'(0));
    pulse_wr_irq();
    chk("t2_starved", 128'(wr_starved), 128'(1));
    chk("t2_done_cnt", 128'(wr_done_cnt), 128'(2));
    chk("t2_no_err", 128'(err_sticky), 128'(0));
    pulse_wr_irq();
    chk("t2_spur_wr_err", 128'(err_sticky), 128'(3'b010));
    chk("t2_done_cnt_hold", 128'(wr_done_cnt), 128'(2));

    // Five back-to-back descriptors with depth 4
    do_reset();
    for (int i = 0; i < 5; i++)
      post(1'b0, 64'h3000_0000 + 64'(i) * 64'h1000, 64'h40 * 64'(i + 1), 1'b1);
    chk("t3_no_stall", 128'(wait_sum), 128'(0));
    chk("t3_ready_full", 128'(dif.desc_ready), 128'(0));
    dif.desc_is_read = 1'b1;
    #1;
    chk("t3_ready_rd_side", 128'(dif.desc_ready), 128'(1));
    dif.desc_is_read = 1'b0;
    repeat (6) tick();
    chk("t3_single_upd", 128'(wr_upd_n), 128'(1));
    for (int i = 0; i < 4; i++) begin
      pulse_wr_irq();
      wait_wr_upd(i + 2);
    end
    chk("t3_all_loaded", 128'(wr_upd_n), 128'(5));
    chk("t3_sb_empty", 128'(wr_q.size()), 128'(0));

    // Bad descriptors and spurious read interrupt
    do_reset();
    post(1'b0, 64'h1000_0000, 64'd0, 1'b0);
    chk("t4_err_size0", 128'(err_sticky), 128'(3'b001));
    post(1'b0, 64'h1000_0020, 64'd1024, 1'b0);
    post(1'b1, 64'h1000_0000, 64'h30, 1'b0);
    repeat (5) tick();
    chk("t4_no_upd", 128'(wr_upd_n + rd_upd_n), 128'(0));
    chk("t4_err_only_bad", 128'(err_sticky), 128'(3'b001));
    read_interrupt = 1'b1;
    tick();
    read_interrupt = 1'b0;
    chk("t4_spur_rd", 128'(err_sticky), 128'(3'b101));
    chk("t4_rd_cnt", 128'(rd_done_cnt), 128'(0));

    // Finish gating
    do_reset();
    host_finish = 1'b1;
    tick();
    host_finish = 1'b0;
    host_finish = 1'b1;
    tick();
    host_finish = 1'b0;
    repeat (5) tick();
    chk("t5_no_fin_idle", 128'(rec_fin_n), 128'(0));
    post(1'b0, 64'h4000_0000, 64'h80, 1'b1);
    wait_wr_upd(1);
    repeat (4) tick();
    chk("t5_fin_once", 128'(rec_fin_n), 128'(1));
    chk("t5_fin_first_active", 128'(rec_fin_upd), 128'(1));

    // Reset while active with queued descriptors
    do_reset();
    for (int i = 0; i < 3; i++) post(1'b0, 64'h5000_0000 + 64'(i) * 64'h40, 64'h40, 1'b1);
    begin
      int n = 0;
      while (!write_buf_update && n < 20) begin tick(); n++; end
      chk("t6_upd_seen", 128'(write_buf_update), 128'(1));
    end
    #2;
    sync_rst_n = 1'b0;
    wr_q.delete();
    #1;
    chk("t6_upd_trunc", 128'(write_buf_update), 128'(0));
    chk("t6_addr_rst",  128'(write_buf_addr), 128'(0));
    chk("t6_size_rst",  128'(write_buf_size), 128'(0));
    repeat (2) @(posedge clk);
    #3;
    sync_rst_n = 1'b1;
    wr_upd_n = 0;
    repeat (8) tick();
    chk("t6_no_upd_after", 128'(wr_upd_n), 128'(0));
    chk("t6_ready", 128'(dif.desc_ready), 128'(1));
    post(1'b0, 64'h6000_0000, 64'h100, 1'b1);
    wait_wr_upd(1);
    chk("t6_new_loaded", 128'(wr_q.size()), 128'(0));

    // Read side runs independently
    do_reset();
    post(1'b1, 64'h7000_0000, 64'h40, 1'b1);
    wait_rd_upd(1);
    chk("t7_rd_not_starved", 128'(rd_starved), 128'(0));
    read_interrupt = 1'b1;
    tick();
    read_interrupt = 1'b0;
    chk("t7_rd_starved", 128'(rd_starved), 128'(1));
    chk("t7_rd_cnt", 128'(rd_done_cnt), 128'(1));
    chk("t7_wr_quiet", 128'({wr_upd_n, 16'(wr_done_cnt)}), 128'(0));
    chk("t7_err", 128'(err_sticky), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
